// File: rtl/sao_pkg.sv
// Shared SAO types and constants used by the mask, statistics and decision stages.
package sao_pkg;

  localparam int N_PIX     = 4;
  localparam int N_EO_TYPE = 4;
  localparam int DIFF_LEN  = 9;
  localparam int CNT_LEN   = 13;
  localparam int SUM_LEN   = 21;

  typedef enum logic [1:0] {EO_HOR, EO_VER, EO_135, EO_45} eo_type_e;

  localparam logic [2:0] SAO_CAT_NONE = 3'd0;
  localparam logic [2:0] SAO_CAT_1    = 3'd1;
  localparam logic [2:0] SAO_CAT_2    = 3'd2;
  localparam logic [2:0] SAO_CAT_3    = 3'd3;
  localparam logic [2:0] SAO_CAT_4    = 3'd4;

  typedef logic        [CNT_LEN-1:0] stat_cnt_t;
  typedef logic signed [SUM_LEN-1:0] stat_sum_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_FLUSH, ST_DONE} acc_state_e;

endpackage

// File: rtl/sao_blk_cat_sum.sv
// Per-EO-type reduction of one 2x2 beat: masked pixel count and diff sum for categories 1..4.
module sao_blk_cat_sum
  import sao_pkg::*;
#(
  parameter int n_pix    = N_PIX,
  parameter int diff_len = DIFF_LEN
) (
  input  logic [n_pix-1:0][2:0]          cat,
  input  logic [n_pix-1:0][diff_len-1:0] diff,
  input  logic [n_pix-1:0]               pmask,
  output logic [3:0][2:0]                bcnt,
  output logic [3:0][diff_len+1:0]       bsum
);

  // Categories 0 and 5..7 never match 1..4, so they fall out without extra logic.
  always_comb begin
    bcnt = '0;
    bsum = '0;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < n_pix; p++) begin
        if (pmask[p] && (cat[p] == SAO_CAT_1 + 3'(c))) begin
          bcnt[c] = bcnt[c] + 3'd1;
          bsum[c] = bsum[c] + {{2{diff[p][diff_len-1]}}, diff[p]};
        end
      end
    end
  end

endmodule

// File: rtl/sao_eo_stat_acc.sv
// SAO edge-offset statistics accumulator: per-CTU, per-type, per-category counts and diff sums.
module sao_eo_stat_acc
  import sao_pkg::*;
#(
  parameter int n_pix     = N_PIX,
  parameter int n_eo_type = N_EO_TYPE,
  parameter int diff_len  = DIFF_LEN,
  parameter int cnt_len   = CNT_LEN,
  parameter int sum_len   = SUM_LEN
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  input  logic [n_eo_type-1:0][n_pix-1:0][2:0]  in_cat,
  input  logic [n_pix-1:0][diff_len-1:0]        in_diff,
  input  logic [n_eo_type-1:0][n_pix-1:0]       b_use,
  output logic                                  stat_valid,
  input  logic                                  stat_ready,
  output logic [n_eo_type-1:0][3:0][cnt_len-1:0] stat_cnt,
  output logic [n_eo_type-1:0][3:0][sum_len-1:0] stat_sum
);

  localparam int bsum_len = diff_len + 2;

  acc_state_e state, state_nxt;
  logic       accept;
  logic       s1_vld;
  logic [n_eo_type-1:0][3:0][2:0]          bcnt, s1_cnt;
  logic [n_eo_type-1:0][3:0][bsum_len-1:0] bsum, s1_sum;

  assign in_ready   = (state == ST_ACC);
  assign stat_valid = (state == ST_DONE);
  // A beat coinciding with start belongs to the aborted CTU and is dropped.
  assign accept     = in_valid && in_ready && !start;

  for (genvar t = 0; t < n_eo_type; t++) begin : g_type
    sao_blk_cat_sum #(
      .n_pix    (n_pix),
      .diff_len (diff_len)
    ) u_cat_sum (
      .cat   (in_cat[t]),
      .diff  (in_diff),
      .pmask (b_use[t]),
      .bcnt  (bcnt[t]),
      .bsum  (bsum[t])
    );
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_ACC;
    end else begin
      case (state)
        ST_ACC:   if (accept && in_last) state_nxt = ST_FLUSH;
        ST_FLUSH: state_nxt = ST_DONE;
        ST_DONE:  if (stat_ready) state_nxt = ST_IDLE;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_vld <= 1'b0;
      s1_cnt <= '0;
      s1_sum <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_cnt <= bcnt;
        s1_sum <= bsum;
      end
    end
  end

  // Start wins over a pending stage-1 beat so an aborted CTU leaves no residue.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_cnt <= '0;
      stat_sum <= '0;
    end else if (start) begin
      stat_cnt <= '0;
      stat_sum <= '0;
    end else if (s1_vld) begin
      for (int t = 0; t < n_eo_type; t++) begin
        for (int c = 0; c < 4; c++) begin
          stat_cnt[t][c] <= stat_cnt[t][c] + {{(cnt_len-3){1'b0}}, s1_cnt[t][c]};
          stat_sum[t][c] <= stat_sum[t][c] +
                            {{(sum_len-bsum_len){s1_sum[t][c][bsum_len-1]}}, s1_sum[t][c]};
        end
      end
    end
  end

endmodule

// File: tb/tb_sao_eo_stat_acc.sv
// Directed bench for sao_eo_stat_acc: single-beat vector table plus multi-cycle corner sequences.
module tb_sao_eo_stat_acc;

  localparam int NT = 4;
  localparam int NP = 4;
  localparam int DL = 9;
  localparam int CL = 13;
  localparam int SL = 21;

  typedef logic [NP-1:0][2:0]           cat_row_t;
  typedef logic [NP-1:0][DL-1:0]        diff_t;
  typedef logic [3:0][CL-1:0]           cnt_row_t;
  typedef logic [3:0][SL-1:0]           sum_row_t;
  typedef logic [NT-1:0][3:0][CL-1:0]   cnt_all_t;
  typedef logic [NT-1:0][3:0][SL-1:0]   sum_all_t;

  typedef struct {
    string                      name;
    logic [NT-1:0][NP-1:0][2:0] cat;
    diff_t                      diff;
    logic [NT-1:0][NP-1:0]      bu;
    cnt_all_t                   cnt;
    sum_all_t                   sum;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic stat_ready = 1'b0;
  logic in_ready;
  logic stat_valid;
  logic [NT-1:0][NP-1:0][2:0] in_cat = '0;
  diff_t                      in_diff = '0;
  logic [NT-1:0][NP-1:0]      b_use = '0;
  cnt_all_t                   stat_cnt;
  sum_all_t                   stat_sum;

  int n_chk = 0;
  int n_fail = 0;

  vec_t tv[3];

  always #5 clk = ~clk;

  sao_eo_stat_acc dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_cat     (in_cat),
    .in_diff    (in_diff),
    .b_use      (b_use),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .stat_cnt   (stat_cnt),
    .stat_sum   (stat_sum)
  );

  function automatic cat_row_t cats(int c0, int c1, int c2, int c3);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic diff_t diffs(int d0, int d1, int d2, int d3);
    return {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
  endfunction

  function automatic cnt_row_t cnts(int a, int b, int c, int d);
    return {13'(d), 13'(c), 13'(b), 13'(a)};
  endfunction

  function automatic sum_row_t sums(int a, int b, int c, int d);
    return {21'(d), 21'(c), 21'(b), 21'(a)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_v(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_stats(string nm, cnt_all_t ec, sum_all_t es);
    n_chk++;
    if (stat_cnt !== ec) begin
      n_fail++;
      $display("FAIL %s cnt: got %h, expected %h", nm, stat_cnt, ec);
    end
    n_chk++;
    if (stat_sum !== es) begin
      n_fail++;
      $display("FAIL %s sum: got %h, expected %h", nm, stat_sum, es);
    end
  endtask

  task automatic release_stats(string nm);
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
    chk_v({nm, " idle valid"}, int'(stat_valid), 0);
  endtask

  cnt_all_t ec, zc;
  sum_all_t es, zs;
  int       bubbles;
  int       stable;

  initial begin
    zc = '0;
    zs = '0;

    // single beat: mixed categories, cats 5..7 treated as none
    tv[0].name = "single";
    tv[0].cat[0] = cats(1, 1, 2, 4);
    tv[0].cat[1] = cats(0, 0, 0, 0);
    tv[0].cat[2] = cats(3, 3, 3, 3);
    tv[0].cat[3] = cats(5, 6, 7, 4);
    tv[0].diff   = diffs(3, -5, 7, 100);
    tv[0].bu     = '1;
    tv[0].cnt[0] = cnts(2, 1, 0, 1);   tv[0].sum[0] = sums(-2, 7, 0, 100);
    tv[0].cnt[1] = cnts(0, 0, 0, 0);   tv[0].sum[1] = sums(0, 0, 0, 0);
    tv[0].cnt[2] = cnts(0, 0, 4, 0);   tv[0].sum[2] = sums(0, 0, 105, 0);
    tv[0].cnt[3] = cnts(0, 0, 0, 1);   tv[0].sum[3] = sums(0, 0, 0, 100);

    // masking: pixel p is bit p of b_use
    tv[1].name = "mask";
    for (int t = 0; t < NT; t++) tv[1].cat[t] = cats(3, 3, 3, 3);
    tv[1].diff  = diffs(10, 10, 10, 10);
    tv[1].bu[0] = 4'b1111;
    tv[1].bu[1] = 4'b1100;
    tv[1].bu[2] = 4'b1110;
    tv[1].bu[3] = 4'b0000;
    tv[1].cnt[0] = cnts(0, 0, 4, 0);   tv[1].sum[0] = sums(0, 0, 40, 0);
    tv[1].cnt[1] = cnts(0, 0, 2, 0);   tv[1].sum[1] = sums(0, 0, 20, 0);
    tv[1].cnt[2] = cnts(0, 0, 3, 0);   tv[1].sum[2] = sums(0, 0, 30, 0);
    tv[1].cnt[3] = cnts(0, 0, 0, 0);   tv[1].sum[3] = sums(0, 0, 0, 0);

    // extreme diff values exercise sign extension
    tv[2].name = "extreme";
    tv[2].cat[0] = cats(1, 2, 3, 4);
    tv[2].cat[1] = cats(1, 1, 1, 1);
    tv[2].cat[2] = cats(2, 2, 0, 0);
    tv[2].cat[3] = cats(4, 0, 4, 0);
    tv[2].diff   = diffs(255, -256, -1, 0);
    tv[2].bu     = '1;
    tv[2].cnt[0] = cnts(1, 1, 1, 1);   tv[2].sum[0] = sums(255, -256, -1, 0);
    tv[2].cnt[1] = cnts(4, 0, 0, 0);   tv[2].sum[1] = sums(-2, 0, 0, 0);
    tv[2].cnt[2] = cnts(0, 2, 0, 0);   tv[2].sum[2] = sums(0, -1, 0, 0);
    tv[2].cnt[3] = cnts(0, 0, 0, 2);   tv[2].sum[3] = sums(0, 0, 0, 254);

    // reset state
    tick();
    chk_v("reset stat_valid", int'(stat_valid), 0);
    chk_v("reset in_ready", int'(in_ready), 0);
    chk_stats("reset", zc, zs);
    arst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_v({tv[i].name, " in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1; in_last = 1'b1;
      in_cat = tv[i].cat; in_diff = tv[i].diff; b_use = tv[i].bu;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      chk_v({tv[i].name, " flush valid"}, int'(stat_valid), 0);
      tick();
      chk_v({tv[i].name, " done valid"}, int'(stat_valid), 1);
      chk_stats(tv[i].name, tv[i].cnt, tv[i].sum);
      release_stats(tv[i].name);
    end

    // full CTU: 1024 back-to-back beats
    in_cat = {NT{cats(1, 1, 1, 1)}};
    in_diff = diffs(-255, -255, -255, -255);
    b_use = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    bubbles = 0;
    for (int i = 0; i < 1024; i++) begin
      in_last = (i == 1023);
      if (in_ready !== 1'b1) bubbles++;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk_v("ctu bubbles", bubbles, 0);
    chk_v("ctu flush valid", int'(stat_valid), 0);
    tick();
    chk_v("ctu done valid", int'(stat_valid), 1);
    for (int t = 0; t < NT; t++) begin
      ec[t] = cnts(4096, 0, 0, 0);
      es[t] = sums(-1044480, 0, 0, 0);
    end
    chk_stats("ctu", ec, es);

    // hold in DONE with stat_ready low while beats are offered
    stable = 1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_last = 1'b1;
      tick();
      if (stat_valid !== 1'b1 || stat_cnt !== ec || stat_sum !== es) stable = 0;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk_v("hold stable", stable, 1);
    release_stats("hold");
    chk_v("hold idle in_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();
    chk_stats("idle keep", ec, es);

    // abort mid-CTU; beat offered alongside start is dropped
    in_cat = {NT{cats(1, 1, 1, 1)}};
    in_diff = diffs(10, 10, 10, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    in_cat = {NT{cats(3, 3, 3, 3)}};
    in_diff = diffs(7, 7, 7, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_cat = {NT{cats(2, 2, 2, 2)}};
    in_diff = diffs(5, 5, 5, 5);
    tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk_v("abort done valid", int'(stat_valid), 1);
    for (int t = 0; t < NT; t++) begin
      ec[t] = cnts(0, 8, 0, 0);
      es[t] = sums(0, 40, 0, 0);
    end
    chk_stats("abort", ec, es);
    release_stats("abort");

    // async reset during FLUSH
    in_cat = {NT{cats(4, 4, 4, 4)}};
    in_diff = diffs(1, 1, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    chk_v("arst stat_valid", int'(stat_valid), 0);
    chk_stats("arst", zc, zs);
    tick();
    arst_n = 1'b1;
    stable = 1;
    in_valid = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (in_ready !== 1'b0) stable = 0;
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    chk_v("post-reset ignored", stable, 1);
    chk_v("post-reset stat_valid", int'(stat_valid), 0);
    chk_stats("post-reset", zc, zs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
